// File: rtl/osd_tracesample_mc.sv
// Multi-channel trace sampler: per-channel FIFOs with saturating overflow counters, round-robin merged onto one valid/ready stream.
// Optional macro OSD_TRACESAMPLE_DROP_STATS_EN enables the saturating drop_total counter (otherwise drop_total is tied to 0).
module osd_tracesample_mc #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4,
    parameter int OVW      = 16,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] sample_data,
    input  logic [CHANNELS-1:0]       sample_valid,
    output logic [WIDTH-1:0]          fifo_data,
    output logic                      fifo_overflow,
    output logic [CW-1:0]             fifo_channel,
    output logic                      fifo_valid,
    input  logic                      fifo_ready,
    output logic [31:0]               drop_total
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [OVW-1:0] OV_MAX = '1;

    logic [WIDTH-1:0] mem [CHANNELS][DEPTH];
    logic [AW-1:0]    wr_ptr [CHANNELS];
    logic [AW-1:0]    rd_ptr [CHANNELS];
    logic [AW:0]      count  [CHANNELS];
    logic [OVW-1:0]   ov     [CHANNELS];

    logic [CW-1:0]  last_grant;
    logic [CW-1:0]  grant;
    logic [CW-1:0]  hold_ch;
    logic           hold_vld;
    logic [OVW-1:0] hold_rec;
    logic [OVW-1:0] rec_val;
    logic           found;
    logic [CW-1:0]  idx;
    logic           xfer;

    logic [CHANNELS-1:0] req, empty, full, pop_fifo, pop_rec, wr_en, drop;

    always_comb begin
        req   = '0;
        empty = '0;
        full  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            empty[c] = (count[c] == '0);
            full[c]  = (count[c] == DEPTH_C);
            req[c]   = !empty[c] || (ov[c] != '0);
        end
    end

    // A stalled word keeps its grant so a newly requesting channel cannot steal the slot.
    always_comb begin
        grant = last_grant;
        found = 1'b0;
        idx   = '0;
        if (hold_vld) begin
            grant = hold_ch;
        end else begin
            for (int i = 1; i <= CHANNELS; i++) begin
                idx = CW'((int'(last_grant) + i) % CHANNELS);
                if (!found && req[idx]) begin
                    grant = idx;
                    found = 1'b1;
                end
            end
        end
    end

    // The record value is frozen while stalled; drops during the stall still bump ov.
    always_comb begin
        fifo_valid    = |req;
        rec_val       = hold_vld ? hold_rec : ov[grant];
        fifo_data     = '0;
        fifo_overflow = 1'b0;
        fifo_channel  = '0;
        if (fifo_valid) begin
            fifo_channel  = grant;
            fifo_overflow = empty[grant];
            fifo_data     = empty[grant] ? WIDTH'(rec_val) : mem[grant][rd_ptr[grant]];
        end
        xfer = fifo_valid && fifo_ready;
    end

    always_comb begin
        pop_fifo = '0;
        pop_rec  = '0;
        wr_en    = '0;
        drop     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            pop_fifo[c] = xfer && (grant == CW'(c)) && !empty[c];
            pop_rec[c]  = xfer && (grant == CW'(c)) && empty[c];
            wr_en[c]    = sample_valid[c] && ((ov[c] == '0) || pop_rec[c])
                          && (!full[c] || pop_fifo[c]);
            drop[c]     = sample_valid[c] && !wr_en[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
                ov[c]     <= '0;
            end
            last_grant <= CW'(CHANNELS - 1);
            hold_vld   <= 1'b0;
            hold_ch    <= '0;
            hold_rec   <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_en[c])
                    wr_ptr[c] <= wr_ptr[c] + AW'(1);
                if (pop_fifo[c])
                    rd_ptr[c] <= rd_ptr[c] + AW'(1);
                if (wr_en[c] && !pop_fifo[c])
                    count[c] <= count[c] + (AW+1)'(1);
                else if (!wr_en[c] && pop_fifo[c])
                    count[c] <= count[c] - (AW+1)'(1);
                if (pop_rec[c])
                    ov[c] <= '0;
                else if (drop[c] && (ov[c] != OV_MAX))
                    ov[c] <= ov[c] + OVW'(1);
            end
            if (xfer)
                last_grant <= grant;
            hold_vld <= fifo_valid && !fifo_ready;
            hold_ch  <= grant;
            hold_rec <= rec_val;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_en[c])
                mem[c][wr_ptr[c]] <= sample_data[c*WIDTH +: WIDTH];
        end
    end

`ifdef OSD_TRACESAMPLE_DROP_STATS_EN
    logic [32:0] drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_total};
        for (int c = 0; c < CHANNELS; c++)
            drop_sum = drop_sum + 33'(drop[c]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            drop_total <= '0;
        else
            drop_total <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
`else
    assign drop_total = '0;
`endif

endmodule
